// File: rtl/perceptron_train_sequencer.sv
// perceptron_train_sequencer
//
// Epoch scheduler for one perceptron. It holds a small sample memory and replays it
// each epoch, first as a training pass and then as an evaluation pass. It scores the
// evaluation predictions and stops after max_epochs epochs. When early stop is
// enabled it also stops after the first epoch that scores full accuracy.
//
// Optional feature:
//   PERCEPTRON_SEQ_EARLY_STOP_EN  when defined, a full evaluation score ends the run
//                                 early with converged=1. When undefined, the run
//                                 always lasts exactly max_epochs epochs.
//
// Ports:
//   clk, rst        clock (posedge) and synchronous active-low reset
//   load_en         write one sample into memory; accepted in IDLE/DONE only
//   load_addr       sample index
//   load_values     sample inputs, with input i at [i*data_width +: data_width]
//   load_expected   sample target
//   lr_in           learning rate, latched when start is accepted
//   start           one-cycle pulse that begins a run (IDLE/DONE only)
//   busy, done      run in progress / run finished
//   converged       final evaluation scored num_samples/num_samples
//   epoch_count     number of epochs completed
//   correct_count   score of the latest evaluation pass
//   values, expected, training, learning_rate   drive the perceptron
//   prediction      perceptron output, valid one cycle after its sample is presented
module perceptron_train_sequencer #(
    parameter int unsigned input_units = 2,
    parameter int unsigned num_samples = 4,
    parameter int unsigned max_epochs  = 10,
    parameter int unsigned data_width  = 16
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   load_en,
    input  logic [((num_samples > 1) ? $clog2(num_samples) : 1)-1:0] load_addr,
    input  logic [input_units*data_width-1:0]                      load_values,
    input  logic [data_width-1:0]                                  load_expected,
    input  logic [data_width-1:0]                                  lr_in,
    input  logic                                                   start,
    output logic                                                   busy,
    output logic                                                   done,
    output logic                                                   converged,
    output logic [$clog2(max_epochs+1)-1:0]                        epoch_count,
    output logic [$clog2(num_samples+1)-1:0]                       correct_count,
    output logic [input_units*data_width-1:0]                      values,
    output logic [data_width-1:0]                                  expected,
    output logic                                                   training,
    output logic [data_width-1:0]                                  learning_rate,
    input  logic [data_width-1:0]                                  prediction
);

    localparam int unsigned AddrW  = (num_samples > 1) ? $clog2(num_samples) : 1;
    localparam int unsigned EpochW = $clog2(max_epochs + 1);
    localparam int unsigned CntW   = $clog2(num_samples + 1);
    localparam int unsigned VecW   = input_units * data_width;

    localparam logic [AddrW-1:0]  LastIdx     = AddrW'(num_samples - 1);
    localparam logic [EpochW-1:0] LastEpoch   = EpochW'(max_epochs - 1);
    localparam logic [CntW-1:0]   NumSamplesC = CntW'(num_samples);

`ifdef PERCEPTRON_SEQ_EARLY_STOP_EN
    localparam bit EarlyStop = 1'b1;
`else
    localparam bit EarlyStop = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StTrain,
        StEval,
        StDrain,
        StCheck,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [AddrW-1:0]    idx_q, idx_d;
    logic [CntW-1:0]     score_q, score_d;
    logic [data_width-1:0] exp_dly_q, exp_dly_d;
    logic                dly_valid_q, dly_valid_d;
    logic [EpochW-1:0]   epoch_q, epoch_d;
    logic [CntW-1:0]     correct_q, correct_d;
    logic                converged_q, converged_d;
    logic [data_width-1:0] lr_q, lr_d;

    // The sample memory has no reset, so its contents persist across runs and resets.
    logic [VecW-1:0]       mem_values_q   [num_samples];
    logic [data_width-1:0] mem_expected_q [num_samples];

    logic [VecW-1:0]       rd_values;
    logic [data_width-1:0] rd_expected;
    logic                  addr_ok;
    logic                  load_ok;
    logic                  last_idx;
    logic                  score_hit;
    logic                  full_score;
    logic                  last_epoch;

    // When the depth is not a power of two, writes to unused addresses are dropped.
    if (num_samples == (1 << AddrW)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = (32'(load_addr) < num_samples);
    end

    assign load_ok = rst && load_en && addr_ok && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem_values_q[load_addr]   <= load_values;
            mem_expected_q[load_addr] <= load_expected;
        end
    end

    assign rd_values   = mem_values_q[idx_q];
    assign rd_expected = mem_expected_q[idx_q];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            score_q     <= '0;
            exp_dly_q   <= '0;
            dly_valid_q <= 1'b0;
            epoch_q     <= '0;
            correct_q   <= '0;
            converged_q <= 1'b0;
            lr_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            score_q     <= score_d;
            exp_dly_q   <= exp_dly_d;
            dly_valid_q <= dly_valid_d;
            epoch_q     <= epoch_d;
            correct_q   <= correct_d;
            converged_q <= converged_d;
            lr_q        <= lr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        score_d     = score_q;
        exp_dly_d   = exp_dly_q;
        dly_valid_d = dly_valid_q;
        epoch_d     = epoch_q;
        correct_d   = correct_q;
        converged_d = converged_q;
        lr_d        = lr_q;

        values   = '0;
        expected = '0;
        training = 1'b0;

        last_idx   = (idx_q == LastIdx);
        // A prediction is only scored when a sample was presented in the previous cycle.
        score_hit  = dly_valid_q && (prediction == exp_dly_q);
        full_score = (score_q == NumSamplesC);
        last_epoch = (epoch_q >= LastEpoch);

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StTrain;
                    idx_d       = '0;
                    epoch_d     = '0;
                    correct_d   = '0;
                    converged_d = 1'b0;
                    lr_d        = lr_in;
                end
            end
            StTrain: begin
                values   = rd_values;
                expected = rd_expected;
                training = 1'b1;
                if (last_idx) begin
                    state_d     = StEval;
                    idx_d       = '0;
                    score_d     = '0;
                    dly_valid_d = 1'b0;
                end else begin
                    idx_d = idx_q + AddrW'(1);
                end
            end
            StEval: begin
                values      = rd_values;
                expected    = exp_dly_q;
                score_d     = score_q + CntW'(score_hit);
                exp_dly_d   = rd_expected;
                dly_valid_d = 1'b1;
                if (last_idx) begin
                    state_d = StDrain;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AddrW'(1);
                end
            end
            StDrain: begin
                // Scores the prediction for the last evaluation sample.
                expected    = exp_dly_q;
                score_d     = score_q + CntW'(score_hit);
                dly_valid_d = 1'b0;
                state_d     = StCheck;
            end
            StCheck: begin
                epoch_d   = epoch_q + EpochW'(1);
                correct_d = score_q;
                idx_d     = '0;
                if ((EarlyStop && full_score) || last_epoch) begin
                    state_d     = StDone;
                    converged_d = full_score;
                end else begin
                    state_d = StTrain;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy          = (state_q != StIdle) && (state_q != StDone);
    assign done          = (state_q == StDone);
    assign converged     = converged_q;
    assign epoch_count   = epoch_q;
    assign correct_count = correct_q;
    assign learning_rate = lr_q;

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Bench for perceptron_train_sequencer. A behavioural perceptron is attached to the
// DUT. The bench predicts each run's outcome from the sample set with a run-level
// epoch loop.
module tb_perceptron_train_sequencer;

    localparam int NS = 4;
    localparam int ME = 10;
    localparam int EPOCH_CYC = 2 * NS + 2;
    localparam logic [15:0] O = 16'h0100;
    localparam logic [15:0] Z = 16'h0000;

`ifdef PERCEPTRON_SEQ_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, load_en, start;
    logic [1:0]  load_addr;
    logic [31:0] load_values;
    logic [15:0] load_expected, lr_in, prediction;
    logic        busy, done, converged, training;
    logic [3:0]  epoch_count;
    logic [2:0]  correct_count;
    logic [31:0] values;
    logic [15:0] expected, learning_rate;

    perceptron_train_sequencer #(
        .input_units(2), .num_samples(NS), .max_epochs(ME), .data_width(16)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_values(load_values), .load_expected(load_expected), .lr_in(lr_in),
        .start(start), .busy(busy), .done(done), .converged(converged),
        .epoch_count(epoch_count), .correct_count(correct_count), .values(values),
        .expected(expected), .training(training), .learning_rate(learning_rate),
        .prediction(prediction)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int w0;
        int w1;
        int b;
    } wts_t;

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Step activation: ONE when the weighted sum is positive, else 0.
    function automatic logic [15:0] act(input wts_t w, input logic [15:0] a,
                                        input logic [15:0] c);
        int s;
        s = w.b + ((w.w0 * sx(a)) >>> 8) + ((w.w1 * sx(c)) >>> 8);
        return (s > 0) ? O : Z;
    endfunction

    function automatic wts_t upd(input wts_t w, input logic [15:0] a, input logic [15:0] c,
                                 input logic [15:0] e, input logic [15:0] lr);
        wts_t n;
        int   d;
        d    = (sx(lr) * (sx(e) - sx(act(w, a, c)))) >>> 8;
        n    = w;
        n.w0 = w.w0 + ((d * sx(a)) >>> 8);
        n.w1 = w.w1 + ((d * sx(c)) >>> 8);
        n.b  = w.b + d;
        return n;
    endfunction

    // Behavioural perceptron peer: inputs are staged mid-cycle. The registered prediction
    // and weight update happen at the edge that ends the presentation cycle.
    wts_t        pw;
    logic [31:0] stg_values;
    logic [15:0] stg_exp, stg_lr;
    logic        stg_train;

    always @(negedge clk) begin
        stg_values <= values;
        stg_exp    <= expected;
        stg_train  <= training;
        stg_lr     <= learning_rate;
    end

    always @(posedge clk) begin
        if (!rst) begin
            pw         <= '0;
            prediction <= '0;
        end else begin
            prediction <= act(pw, stg_values[15:0], stg_values[31:16]);
            if (stg_train) pw <= upd(pw, stg_values[15:0], stg_values[31:16], stg_exp, stg_lr);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] req);
        n_checks++;
        if (actual !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, req);
        end
    endtask

    logic [15:0] img_x0 [NS];
    logic [15:0] img_x1 [NS];
    logic [15:0] img_e  [NS];

    // Run-level model: train over all samples, evaluate, then decide whether to stop.
    task automatic ref_run(input logic [15:0] lr, output int ep, output int sc, output bit cv);
        wts_t w;
        w  = '0;
        ep = 0;
        sc = 0;
        cv = 1'b0;
        for (int e = 1; e <= ME; e++) begin
            for (int k = 0; k < NS; k++) w = upd(w, img_x0[k], img_x1[k], img_e[k], lr);
            sc = 0;
            for (int k = 0; k < NS; k++) if (act(w, img_x0[k], img_x1[k]) === img_e[k]) sc++;
            ep = e;
            if ((EARLY && sc == NS) || e == ME) begin
                cv = (sc == NS);
                break;
            end
        end
    endtask

    typedef struct packed {
        logic [3:0][15:0] x0;
        logic [3:0][15:0] x1;
        logic [3:0][15:0] e;
        logic [15:0]      lr;
        logic [1:0]       kind;       // 1 = AND, 2 = XOR, 0 = other
        logic             perturb;
        logic             same_cycle;
        int               ep;
        int               sc;
        logic             cv;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(3))
            0:       return Z;
            1:       return O;
            2:       return 16'hFF00;
            default: return 16'($urandom_range(511));
        endcase
    endfunction

    task automatic set_img(input int i);
        for (int k = 0; k < NS; k++) begin
            img_x0[k] = tbl[i].x0[k];
            img_x1[k] = tbl[i].x1[k];
            img_e[k]  = tbl[i].e[k];
        end
    endtask

    task automatic load_sample(input int k);
        load_en       = 1'b1;
        load_addr     = 2'(k);
        load_values   = {img_x1[k], img_x0[k]};
        load_expected = img_e[k];
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Hold reset for three edges while trying to write junk to sample 0.
    task automatic reset_dut();
        rst           = 1'b0;
        load_en       = 1'b1;
        load_addr     = 2'd0;
        load_values   = 32'h5678_1234;
        load_expected = 16'h0ABC;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_converged", 32'(converged), 0);
        check("rst_epoch_count", 32'(epoch_count), 0);
        check("rst_correct_count", 32'(correct_count), 0);
        check("rst_training", 32'(training), 0);
        check("rst_values", values, 0);
        check("rst_expected", 32'(expected), 0);
        check("rst_learning_rate", 32'(learning_rate), 0);
        load_en = 1'b0;
        rst     = 1'b1;
    endtask

    // Call this at a negedge while the DUT is in IDLE or DONE.
    task automatic do_run(input int i);
        int cyc, tc;
        bit to;
        lr_in = tbl[i].lr;
        start = 1'b1;
        if (tbl[i].same_cycle) begin
            load_en       = 1'b1;
            load_addr     = 2'(NS - 1);
            load_values   = {img_x1[NS-1], img_x0[NS-1]};
            load_expected = img_e[NS-1];
        end
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
        check("first_busy", 32'(busy), 1);
        check("first_training", 32'(training), 1);
        check("first_values", values, {img_x1[0], img_x0[0]});
        check("first_expected", 32'(expected), 32'(img_e[0]));
        check("first_lr", 32'(learning_rate), 32'(tbl[i].lr));
        cyc = 0;
        tc  = 0;
        to  = 1'b1;
        for (int t = 0; t < 4 * ME * EPOCH_CYC; t++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            cyc += 32'(busy);
            tc  += 32'(training);
            start   = tbl[i].perturb && (cyc == 3);
            load_en = tbl[i].perturb && (cyc == NS + 2);
            load_addr     = 2'd0;
            load_values   = 32'hDEAD_BEEF;
            load_expected = 16'h7777;
            @(negedge clk);
        end
        start   = 1'b0;
        load_en = 1'b0;
        check("run_timeout", 32'(to), 0);
        check("end_done", 32'(done), 1);
        check("end_busy", 32'(busy), 0);
        check("end_training", 32'(training), 0);
        check("end_values", values, 0);
        check("end_epoch_count", 32'(epoch_count), 32'(tbl[i].ep));
        check("end_correct_count", 32'(correct_count), 32'(tbl[i].sc));
        check("end_converged", 32'(converged), 32'(tbl[i].cv));
        check("run_cycles", 32'(cyc), 32'(tbl[i].ep * EPOCH_CYC));
        check("train_cycles", 32'(tc), 32'(tbl[i].ep * NS));
        if (tbl[i].kind == 2'd1) begin
            check("and_converged", 32'(converged), 1);
            check("and_correct", 32'(correct_count), 4);
            check("and_epochs_le_max", 32'(epoch_count <= 4'(ME)), 1);
`ifndef PERCEPTRON_SEQ_EARLY_STOP_EN
            check("and_epochs_full", 32'(epoch_count), 32'(ME));
            check("and_run_100", 32'(cyc), 100);
`endif
        end
        if (tbl[i].kind == 2'd2) begin
            check("xor_epochs", 32'(epoch_count), 32'(ME));
            check("xor_not_converged", 32'(converged), 0);
            check("xor_correct_lt4", 32'(correct_count < 3'd4), 1);
        end
    endtask

    initial begin
        int ep, sc;
        bit cv;
        rst = 1'b0;
        load_en = 1'b0;
        start = 1'b0;
        load_addr = '0;
        load_values = '0;
        load_expected = '0;
        lr_in = '0;

        // Sample k: x0 = bit 1 of k, x1 = bit 0 of k.
        tbl[0] = '{x0: {O, O, Z, Z}, x1: {O, Z, O, Z}, e: {O, Z, Z, Z}, lr: O, kind: 2'd1,
                   perturb: 1'b0, same_cycle: 1'b0, ep: 0, sc: 0, cv: 1'b0};
        tbl[1] = '{x0: {O, O, Z, Z}, x1: {O, Z, O, Z}, e: {Z, O, O, Z}, lr: O, kind: 2'd2,
                   perturb: 1'b0, same_cycle: 1'b1, ep: 0, sc: 0, cv: 1'b0};
        tbl[2] = tbl[0];
        tbl[2].perturb = 1'b1;
        tbl[6] = '{x0: {O, O, Z, Z}, x1: {O, Z, O, Z}, e: {O, O, O, Z}, lr: 16'h0080,
                   kind: 2'd0, perturb: 1'b0, same_cycle: 1'b0, ep: 0, sc: 0, cv: 1'b0};
        for (int i = 3; i < 6; i++) begin
            tbl[i] = '0;
            for (int k = 0; k < NS; k++) begin
                tbl[i].x0[k] = rnd_val();
                tbl[i].x1[k] = rnd_val();
                tbl[i].e[k]  = ($urandom_range(1) == 1) ? O : Z;
            end
            case ($urandom_range(2))
                0:       tbl[i].lr = O;
                1:       tbl[i].lr = 16'h0080;
                default: tbl[i].lr = 16'h0040;
            endcase
        end
        for (int i = 0; i < 7; i++) begin
            set_img(i);
            ref_run(tbl[i].lr, ep, sc, cv);
            tbl[i].ep = ep;
            tbl[i].sc = sc;
            tbl[i].cv = cv;
        end

        @(negedge clk);
        reset_dut();

        for (int i = 0; i < 7; i++) begin
            set_img(i);
            for (int k = 0; k < NS - (tbl[i].same_cycle ? 1 : 0); k++) load_sample(k);
            reset_dut();
            do_run(i);
        end

        // Reset in the middle of epoch 3 EVAL, then rerun from the retained memory.
        set_img(0);
        for (int k = 0; k < NS; k++) load_sample(k);
        reset_dut();
        lr_in = O;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * EPOCH_CYC + NS + 1) @(negedge clk);
        check("mid_eval_training", 32'(training), 0);
        check("mid_eval_epoch", 32'(epoch_count), 2);
        check("mid_eval_busy", 32'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_training", 32'(training), 0);
        check("midrst_epoch", 32'(epoch_count), 0);
        check("midrst_done", 32'(done), 0);
        rst = 1'b1;
        do_run(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_train_sequencer.md
# perceptron_train_sequencer

Epoch scheduler that drives a single perceptron instance through supervised training and evaluation without testbench involvement. Holds a small sample memory, replays it as a training pass (training=1) then an evaluation pass (training=0) per epoch, scores predictions, and stops on full accuracy or after a maximum epoch count. Sits between a host/loader and the perceptron's values/expected/training/learning_rate/prediction ports. All data is `sfp` from the FixedPoint package; `ONE` is fixed-point 1.0.

## Interface
- input_units, 2, number of perceptron inputs per sample
- num_samples, 4, sample memory depth (≥1)
- max_epochs, 10, epoch limit (≥1)
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- load_en  in  1  write one sample into memory (IDLE/DONE only)
- load_addr  in  $clog2(num_samples) (min 1)  sample index
- load_values  in  sfp[input_units]  sample inputs
- load_expected  in  sfp  sample target
- lr_in  in  sfp  learning rate, captured on start
- start  in  1  one-cycle pulse, begins a run
- busy  out  1  high from start acceptance until DONE
- done  out  1  high in DONE until next start or reset
- converged  out  1  final eval scored num_samples/num_samples
- epoch_count  out  $clog2(max_epochs+1)  epochs completed
- correct_count  out  $clog2(num_samples+1)  score of latest eval pass
- values  out  sfp[input_units]  to perceptron
- expected  out  sfp  to perceptron
- training  out  1  to perceptron
- learning_rate  out  sfp  to perceptron
- prediction  in  sfp  from perceptron, valid one cycle after its sample is presented

## Operation
- States: IDLE → TRAIN → EVAL → DRAIN → CHECK → (TRAIN | DONE); DONE → TRAIN on start.
- IDLE/DONE: training=0, values=0, expected=0. load_en writes memory[load_addr]; ignored in other states. start accepted only in IDLE/DONE; clears epoch_count, correct_count, converged; latches lr_in to learning_rate.
- TRAIN: num_samples cycles; cycle k presents memory[k] with training=1.
- EVAL: num_samples cycles; cycle k presents memory[k] with training=0; expected for sample k delayed one cycle alongside it.
- DRAIN: one cycle, training=0, values=0; scores last sample.
- Scoring: in the cycle after sample k is presented (EVAL k+1 or DRAIN), if prediction == delayed expected (exact bit compare), increment score; score cleared on entering EVAL, copied to correct_count in CHECK.
- CHECK: one cycle; epoch_count += 1. If score == num_samples → converged=1, DONE (subject to Configuration). Else if epoch_count reaches max_epochs → DONE, converged=0. Else → TRAIN.
- Sample index counter wraps 0..num_samples-1, reset to 0 on each phase entry.
- Memory is not cleared by reset; contents persist across runs.

## Timing
- Reset values: busy=0, done=0, converged=0, epoch_count=0, correct_count=0, training=0, values=0, expected=0, learning_rate=0; state IDLE.
- start at edge N → first TRAIN sample presented cycle N+1; busy=1 from N+1.
- One epoch = 2·num_samples + 2 cycles (default 10).
- done/busy update in the cycle after CHECK; correct_count/epoch_count update at the CHECK edge.
- Reset mid-run: next edge returns to IDLE with reset values; perceptron weights are not touched by this block.
- start while busy: ignored. load_en and start in same cycle in IDLE: write completes, run uses new data.

## Configuration
- PERCEPTRON_SEQ_EARLY_STOP_EN defined: CHECK goes to DONE on full score (converged=1) before max_epochs.
- Undefined: always runs exactly max_epochs epochs; converged reflects final epoch's score only.

## Test plan
- Reset: hold rst=0 3 cycles → all outputs 0, state IDLE; load_en during reset writes nothing.
- AND gate, learning_rate=ONE, early stop on: load {0,0→0},{0,ONE→0},{ONE,0→0},{ONE,ONE→ONE}, start → done with converged=1, correct_count=4, epoch_count ≤10; training high exactly 4 cycles per epoch.
- Same data, macro off → epoch_count=10, run length 100 cycles from start to done.
- XOR data ({0,0→0},{0,ONE→ONE},{ONE,0→ONE},{ONE,ONE→0}) → done after 10 epochs, converged=0, correct_count<4.
- Reset asserted mid-EVAL of epoch 3 → next cycle busy=0, training=0, epoch_count=0; subsequent start reruns with retained memory.
- start pulsed during TRAIN and load_en during EVAL → ignored; run results match an unperturbed run.
